// File: rtl/ball_kinematics.sv
// Two-axis ball integrator for the labyrinth.
// Tilt samples drive per-axis velocity and then position, once per divider tick.
// Velocity saturates at +/-VMAX, and optional friction decays it.
// Walls clamp the position and either stop or reflect the ball.
// Sequence per tick: WAIT (tick seen) -> VEL (velocity) -> POS (position, upd, wall_hit).

module ball_kinematics #(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned ACC_W      = 8,
    parameter int unsigned ACC_SHIFT  = 2,
    parameter int unsigned VEL_W      = 8,
    parameter int unsigned VMAX       = 48,
    parameter int unsigned FRIC_SHIFT = 3,
    parameter bit          BOUNCE     = 1'b0,
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned X_MIN      = 10,
    parameter int unsigned X_MAX      = 1270,
    parameter int unsigned Y_MIN      = 10,
    parameter int unsigned Y_MAX      = 790,
    parameter int unsigned X_INIT     = 640,
    parameter int unsigned Y_INIT     = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             recenter,
    input  logic             accel_valid,
    input  logic [ACC_W-1:0] accel_x,
    input  logic [ACC_W-1:0] accel_y,
    output logic [X_W-1:0]   xcenter,
    output logic [Y_W-1:0]   ycenter,
    output logic [VEL_W-1:0] x_vel,
    output logic [VEL_W-1:0] y_vel,
    output logic             upd,
    output logic [3:0]       wall_hit
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    // Two guard bits keep the velocity sum from wrapping before the clamp.
    localparam int unsigned SUM_W = ((ACC_W > VEL_W) ? ACC_W : VEL_W) + 2;
    localparam int unsigned XS_W = X_W + 2;
    localparam int unsigned YS_W = Y_W + 2;

    localparam logic signed [SUM_W-1:0] V_HI = SUM_W'(VMAX);
    localparam logic signed [SUM_W-1:0] V_LO = -V_HI;
    localparam logic signed [XS_W-1:0]  X_LO = XS_W'(X_MIN);
    localparam logic signed [XS_W-1:0]  X_HI = XS_W'(X_MAX);
    localparam logic signed [YS_W-1:0]  Y_LO = YS_W'(Y_MIN);
    localparam logic signed [YS_W-1:0]  Y_HI = YS_W'(Y_MAX);
    localparam logic [X_W-1:0] X_RST = X_W'(X_INIT);
    localparam logic [Y_W-1:0] Y_RST = Y_W'(Y_INIT);

    typedef enum logic [1:0] {StWait, StVel, StPos} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [X_W-1:0]           x_q, x_d;
    logic [Y_W-1:0]           y_q, y_d;
    logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;
    logic signed [ACC_W-1:0]  ax_q, ay_q;
    logic                     upd_q, upd_d;
    logic [3:0]               wall_q, wall_d;
    logic                     tick;
    logic signed [XS_W-1:0]   x_sum;
    logic signed [YS_W-1:0]   y_sum;

    // One velocity step: add scaled tilt, subtract friction, then saturate.
    function automatic logic signed [VEL_W-1:0] vel_step(input logic signed [VEL_W-1:0] v,
                                                          input logic signed [ACC_W-1:0] a);
        logic signed [SUM_W-1:0] v_ext;
        logic signed [SUM_W-1:0] a_ext;
        logic signed [SUM_W-1:0] fric;
        logic signed [SUM_W-1:0] t;
        v_ext = {{(SUM_W-VEL_W){v[VEL_W-1]}}, v};
        a_ext = {{(SUM_W-ACC_W){a[ACC_W-1]}}, a};
        a_ext = a_ext >>> ACC_SHIFT;
        // A zero shift means no friction, not "subtract the whole velocity".
        if (FRIC_SHIFT != 0) begin
            fric = v_ext >>> FRIC_SHIFT;
        end else begin
            fric = '0;
        end
        t = v_ext + a_ext - fric;
        if (t > V_HI) begin
            t = V_HI;
        end else if (t < V_LO) begin
            t = V_LO;
        end
        return t[VEL_W-1:0];
    endfunction

    assign tick = en && (cnt_q == CNT_LAST);

    // Candidate positions from the velocity written in VEL.
    always_comb begin
        x_sum = XS_W'(x_q) + {{(XS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
        y_sum = YS_W'(y_q) + {{(YS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
    end

    // Next-state logic: divider, FSM, velocity and position updates, recenter override.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        upd_d   = 1'b0;
        wall_d  = 4'b0000;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StWait: begin
                if (tick) begin
                    state_d = StVel;
                end
            end
            StVel: begin
                vx_d    = vel_step(vx_q, ax_q);
                vy_d    = vel_step(vy_q, ay_q);
                state_d = StPos;
            end
            StPos: begin
                upd_d   = 1'b1;
                state_d = StWait;
                if (x_sum < X_LO) begin
                    x_d       = X_LO[X_W-1:0];
                    wall_d[0] = 1'b1;
                    vx_d      = BOUNCE ? -vx_q : '0;
                end else if (x_sum > X_HI) begin
                    x_d       = X_HI[X_W-1:0];
                    wall_d[1] = 1'b1;
                    vx_d      = BOUNCE ? -vx_q : '0;
                end else begin
                    x_d = x_sum[X_W-1:0];
                end
                if (y_sum < Y_LO) begin
                    y_d       = Y_LO[Y_W-1:0];
                    wall_d[2] = 1'b1;
                    vy_d      = BOUNCE ? -vy_q : '0;
                end else if (y_sum > Y_HI) begin
                    y_d       = Y_HI[Y_W-1:0];
                    wall_d[3] = 1'b1;
                    vy_d      = BOUNCE ? -vy_q : '0;
                end else begin
                    y_d = y_sum[Y_W-1:0];
                end
            end
            default: state_d = StWait;
        endcase

        // Recenter wins over everything, including an update in flight.
        if (recenter) begin
            state_d = StWait;
            cnt_d   = '0;
            x_d     = X_RST;
            y_d     = Y_RST;
            vx_d    = '0;
            vy_d    = '0;
            upd_d   = 1'b0;
            wall_d  = 4'b0000;
        end
    end

    // State, kinematics and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            cnt_q   <= '0;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            vx_q    <= '0;
            vy_q    <= '0;
            upd_q   <= 1'b0;
            wall_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            upd_q   <= upd_d;
            wall_q  <= wall_d;
        end
    end

    // Tilt sample registers: load whenever a sample arrives, whatever the FSM is doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ax_q <= '0;
            ay_q <= '0;
        end else if (accel_valid) begin
            ax_q <= accel_x;
            ay_q <= accel_y;
        end
    end

    assign xcenter  = x_q;
    assign ycenter  = y_q;
    assign x_vel    = vx_q;
    assign y_vel    = vy_q;
    assign upd      = upd_q;
    assign wall_hit = wall_q;

endmodule

// File: tb/tb_ball_kinematics.sv
// Bench for ball_kinematics.
// Two instances share the same stimulus: u_a (no friction, stop at walls) and u_b
// (friction shift 3, bounce). A behavioural model predicts each update, and the
// prediction is queued when the update's stimulus is driven. It is popped and compared
// on the update pulse.

module tb_ball_kinematics;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       recenter;
    logic       accel_valid;
    logic [7:0] accel_x;
    logic [7:0] accel_y;

    logic [10:0] a_xc, b_xc;
    logic [9:0]  a_yc, b_yc;
    logic [7:0]  a_xv, a_yv, b_xv, b_yv;
    logic        a_upd, b_upd;
    logic [3:0]  a_wall, b_wall;

    typedef struct {
        int px;
        int py;
        int vx;
        int vy;
        int wall;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int m_px[2], m_py[2], m_vx[2], m_vy[2];
    int m_fric[2]   = '{0, 3};
    int m_bounce[2] = '{0, 1};
    int m_ax = 0;
    int m_ay = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_upd = 0;
    int gap = 0;

    int exp_v[6] = '{10, 20, 30, 40, 48, 48};
    int exp_x[6] = '{650, 670, 700, 740, 788, 836};
    int exp_f[3] = '{35, 31, 28};

    ball_kinematics #(.TICK_DIV(8), .FRIC_SHIFT(0), .BOUNCE(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .recenter(recenter), .accel_valid(accel_valid),
        .accel_x(accel_x), .accel_y(accel_y), .xcenter(a_xc), .ycenter(a_yc),
        .x_vel(a_xv), .y_vel(a_yv), .upd(a_upd), .wall_hit(a_wall)
    );

    ball_kinematics #(.TICK_DIV(8), .FRIC_SHIFT(3), .BOUNCE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .recenter(recenter), .accel_valid(accel_valid),
        .accel_x(accel_x), .accel_y(accel_y), .xcenter(b_xc), .ycenter(b_yc),
        .x_vel(b_xv), .y_vel(b_yv), .upd(b_upd), .wall_hit(b_wall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int sat(input int t);
        if (t > 48) return 48;
        if (t < -48) return -48;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_px[i] = 640;
            m_py[i] = 400;
            m_vx[i] = 0;
            m_vy[i] = 0;
        end
    endtask

    function automatic exp_t model_update(input int i);
        exp_t e;
        int t;
        int p;
        e.wall = 0;
        t = m_vx[i] + (m_ax >>> 2);
        if (m_fric[i] != 0) t = t - (m_vx[i] >>> m_fric[i]);
        m_vx[i] = sat(t);
        t = m_vy[i] + (m_ay >>> 2);
        if (m_fric[i] != 0) t = t - (m_vy[i] >>> m_fric[i]);
        m_vy[i] = sat(t);
        p = m_px[i] + m_vx[i];
        if (p < 10) begin
            m_px[i] = 10;
            e.wall |= 1;
            m_vx[i] = (m_bounce[i] != 0) ? -m_vx[i] : 0;
        end else if (p > 1270) begin
            m_px[i] = 1270;
            e.wall |= 2;
            m_vx[i] = (m_bounce[i] != 0) ? -m_vx[i] : 0;
        end else begin
            m_px[i] = p;
        end
        p = m_py[i] + m_vy[i];
        if (p < 10) begin
            m_py[i] = 10;
            e.wall |= 4;
            m_vy[i] = (m_bounce[i] != 0) ? -m_vy[i] : 0;
        end else if (p > 790) begin
            m_py[i] = 790;
            e.wall |= 8;
            m_vy[i] = (m_bounce[i] != 0) ? -m_vy[i] : 0;
        end else begin
            m_py[i] = p;
        end
        e.px = m_px[i];
        e.py = m_py[i];
        e.vx = m_vx[i];
        e.vy = m_vy[i];
        return e;
    endfunction

    // Call at a falling edge; returns at the falling edge where upd is seen.
    task automatic do_update(input int ax, input int ay, input bit load);
        exp_t ea;
        exp_t eb;
        int n;
        if (load) begin
            accel_x = 8'(ax);
            accel_y = 8'(ay);
            accel_valid = 1'b1;
            m_ax = ax;
            m_ay = ay;
        end
        sb_a.push_back(model_update(0));
        sb_b.push_back(model_update(1));
        @(negedge clk);
        accel_valid = 1'b0;
        n = 0;
        while (a_upd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        check_val("upd_seen", int'(a_upd), 1);
        if (a_upd === 1'b1) begin
            gap = cyc - last_upd;
            last_upd = cyc;
            check_val("b_upd_sync", int'(b_upd), 1);
            check_val("a_x", int'(a_xc), ea.px);
            check_val("a_y", int'(a_yc), ea.py);
            check_val("a_vx", int'($signed(a_xv)), ea.vx);
            check_val("a_vy", int'($signed(a_yv)), ea.vy);
            check_val("a_wall", int'(a_wall), ea.wall);
            check_val("b_x", int'(b_xc), eb.px);
            check_val("b_y", int'(b_yc), eb.py);
            check_val("b_vx", int'($signed(b_xv)), eb.vx);
            check_val("b_vy", int'($signed(b_yv)), eb.vy);
            check_val("b_wall", int'(b_wall), eb.wall);
        end else begin
            gap = -1;
        end
    endtask

    // Entered at an upd falling edge; the seventh falling edge after it is the POS cycle.
    task automatic do_recenter();
        repeat (7) @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        check_val("rc_a_upd", int'(a_upd), 0);
        check_val("rc_b_upd", int'(b_upd), 0);
        check_val("rc_a_x", int'(a_xc), 640);
        check_val("rc_a_y", int'(a_yc), 400);
        check_val("rc_a_vx", int'($signed(a_xv)), 0);
        check_val("rc_a_vy", int'($signed(a_yv)), 0);
        check_val("rc_a_wall", int'(a_wall), 0);
        check_val("rc_b_x", int'(b_xc), 640);
        check_val("rc_b_vx", int'($signed(b_xv)), 0);
        model_reset();
        last_upd = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_a, seen_b, min_vx, min_vy, prev, cur, frozen;
        rst_n = 1'b0;
        en = 1'b1;
        recenter = 1'b0;
        accel_valid = 1'b0;
        accel_x = '0;
        accel_y = '0;
        model_reset();
        repeat (3) @(negedge clk);

        check_val("rst_a_x", int'(a_xc), 640);
        check_val("rst_a_y", int'(a_yc), 400);
        check_val("rst_a_vx", int'($signed(a_xv)), 0);
        check_val("rst_a_upd", int'(a_upd), 0);
        check_val("rst_a_wall", int'(a_wall), 0);
        check_val("rst_b_y", int'(b_yc), 400);

        // Idle ball: first update 10 cycles after release, then every 8.
        rst_n = 1'b1;
        last_upd = cyc;
        do_update(0, 0, 1'b1);
        check_val("first_upd_latency", gap, 10);
        do_update(0, 0, 1'b0);
        check_val("upd_period", gap, 8);
        check_val("idle_a_x", int'(a_xc), 640);
        check_val("idle_a_y", int'(a_yc), 400);

        // Steady push to the right until both instances meet the right wall.
        seen_a = 0;
        seen_b = 0;
        for (int k = 0; k < 18; k++) begin
            do_update(40, 0, k == 0);
            if (k < 6) begin
                check_val("ramp_vx", int'($signed(a_xv)), exp_v[k]);
                check_val("ramp_x", int'(a_xc), exp_x[k]);
            end
            if (seen_a == 0 && m_px[0] == 1270) begin
                seen_a = 1;
                check_val("stop_x", int'(a_xc), 1270);
                check_val("stop_vx", int'($signed(a_xv)), 0);
                check_val("stop_wall", int'(a_wall), 2);
            end
            if (seen_b == 0 && m_vx[1] < 0) begin
                seen_b = 1;
                check_val("bounce_x", int'(b_xc), 1270);
                check_val("bounce_vx", int'($signed(b_xv)), -48);
                check_val("bounce_wall", int'(b_wall), 2);
            end
        end
        check_val("stop_reached", seen_a, 1);
        check_val("bounce_reached", seen_b, 1);

        // Full negative tilt: u_a pins in the top-left corner.
        min_vx = 0;
        min_vy = 0;
        for (int k = 0; k < 40; k++) begin
            do_update(-128, -128, k == 0);
            if (int'($signed(a_xv)) < min_vx) min_vx = int'($signed(a_xv));
            if (int'($signed(a_yv)) < min_vy) min_vy = int'($signed(a_yv));
        end
        check_val("pin_x", int'(a_xc), 10);
        check_val("pin_y", int'(a_yc), 10);
        check_val("pin_wall", int'(a_wall), 5);
        check_val("sat_vx", min_vx, -48);
        check_val("sat_vy", min_vy, -48);

        // Recenter in POS; tilt registers survive it.
        do_recenter();
        do_update(0, 0, 1'b0);
        check_val("rc_upd_latency", gap, 10);
        check_val("rc_kept_accel_vx", int'($signed(a_xv)), -32);

        // Build u_b to +40, then let friction decay it.
        do_recenter();
        for (int k = 0; k < 5; k++) begin
            do_update(40, 0, k == 0);
        end
        check_val("fric_start_vx", int'($signed(b_xv)), 40);
        prev = 40;
        for (int k = 0; k < 20; k++) begin
            do_update(0, 0, k == 0);
            cur = int'($signed(b_xv));
            if (k < 3) check_val("fric_vx", cur, exp_f[k]);
            check_val("fric_mono", (cur <= prev && cur >= 0) ? 1 : 0, 1);
            prev = cur;
        end

        // Freeze the divider for 20 cycles.
        en = 1'b0;
        frozen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            frozen += int'(a_upd);
        end
        check_val("freeze_no_upd", frozen, 0);
        en = 1'b1;
        do_update(24, -24, 1'b1);
        check_val("freeze_gap", gap, 28);

        // Asynchronous reset during VEL aborts the update and clears the tilt registers.
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_a_x", int'(a_xc), 640);
        check_val("arst_a_y", int'(a_yc), 400);
        check_val("arst_a_vx", int'($signed(a_xv)), 0);
        check_val("arst_a_upd", int'(a_upd), 0);
        check_val("arst_b_vy", int'($signed(b_yv)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        m_ax = 0;
        m_ay = 0;
        last_upd = cyc;
        do_update(0, 0, 1'b0);
        check_val("arst_upd_latency", gap, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
